// File: rtl/link_credit_tx.sv
`default_nettype none
// ============================================================================
// Module   : link_credit_tx
// Purpose  : Credit-gated flit sender for one inter-tile link. Each VC tracks
//            the free slots in the downstream buffer; a flit is forwarded to
//            the PHY only if its VC has credit.
// Revision : 1.0 - initial release
// ============================================================================
module link_credit_tx #(
    parameter int  NUM_VCS     = 2,
    parameter int  BUFFER_SIZE = 8,
    parameter int  FLIT_WIDTH  = 32,
    localparam int VC_W        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [FLIT_WIDTH-1:0]    flit_in,
    input  logic [VC_W-1:0]          flit_vc,
    input  logic                     flit_valid,
    output logic                     flit_ready,
    input  logic                     credit_valid,
    input  logic [VC_W-1:0]          credit_vc,
    output logic                     phy_start,
    output logic [FLIT_WIDTH-1:0]    phy_flit,
    input  logic                     phy_done,
    output logic [NUM_VCS*CNT_W-1:0] credits,
    output logic                     credit_err,
    output logic                     busy
);

    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_credits      [NUM_VCS];
    logic [CNT_W-1:0]        w_credits_next [NUM_VCS];
    logic [FLIT_WIDTH-1:0]   r_phy_flit;
    logic                    r_credit_err;
    logic                    w_vc_has_credit;
    logic                    w_credit_vc_ok;
    logic                    w_accept;
    logic                    w_overflow;
    logic                    w_err_set;

    // Out-of-range VC codes match no entry, so they never get credit.
    always_comb begin
        w_vc_has_credit = 1'b0;
        w_credit_vc_ok  = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (flit_vc == VC_W'(v)) begin
                w_vc_has_credit = (r_credits[v] != '0);
            end
            if (credit_vc == VC_W'(v)) begin
                w_credit_vc_ok = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        flit_ready   = 1'b0;
        phy_start    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                flit_ready = w_vc_has_credit;
                if (flit_valid && w_vc_has_credit) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                phy_start    = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (phy_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept = flit_valid && flit_ready;

    // A decrement requires a non-zero count, so a same-VC decrement plus
    // increment can never overflow; only a lone increment at full can.
    always_comb begin
        w_overflow = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            w_credits_next[v] = r_credits[v];
            if (w_accept && (flit_vc == VC_W'(v)) &&
                !(credit_valid && (credit_vc == VC_W'(v)))) begin
                w_credits_next[v] = r_credits[v] - C_ONE;
            end else if (credit_valid && (credit_vc == VC_W'(v)) &&
                         !(w_accept && (flit_vc == VC_W'(v)))) begin
                if (r_credits[v] == C_FULL) begin
                    w_overflow = 1'b1;
                end else begin
                    w_credits_next[v] = r_credits[v] + C_ONE;
                end
            end
        end
    end

    assign w_err_set = w_overflow || (credit_valid && !w_credit_vc_ok);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state      <= ST_IDLE;
            r_phy_flit   <= '0;
            r_credit_err <= 1'b0;
            for (int v = 0; v < NUM_VCS; v++) begin
                r_credits[v] <= C_FULL;
            end
        end else begin
            r_state <= w_state_next;
            for (int v = 0; v < NUM_VCS; v++) begin
                r_credits[v] <= w_credits_next[v];
            end
            if (w_accept) begin
                r_phy_flit <= flit_in;
            end
            if (w_err_set) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    generate
        for (genvar v = 0; v < NUM_VCS; v++) begin : g_credits
            assign credits[v*CNT_W +: CNT_W] = r_credits[v];
        end
    endgenerate

    assign phy_flit   = r_phy_flit;
    assign credit_err = r_credit_err;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_link_credit_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_credit_tx
// Purpose  : Directed scenarios plus randomized traffic against a
//            cycle-level reference model of the credit sender.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_credit_tx;

    localparam int NUM_VCS     = 2;
    localparam int BUFFER_SIZE = 8;
    localparam int FLIT_WIDTH  = 32;
    localparam int VC_W        = 1;
    localparam int CNT_W       = $clog2(BUFFER_SIZE + 1);

    logic                     clk = 1'b0;
    logic                     n_rst;
    logic [FLIT_WIDTH-1:0]    flit_in;
    logic [VC_W-1:0]          flit_vc;
    logic                     flit_valid;
    logic                     flit_ready;
    logic                     credit_valid;
    logic [VC_W-1:0]          credit_vc;
    logic                     phy_start;
    logic [FLIT_WIDTH-1:0]    phy_flit;
    logic                     phy_done;
    logic [NUM_VCS*CNT_W-1:0] credits;
    logic                     credit_err;
    logic                     busy;

    int errors = 0;
    int checks = 0;

    // Reference model: flit age since acceptance (1 = start cycle, >=2 = waiting).
    bit                  m_busy;
    int                  m_age;
    int                  m_cred [NUM_VCS];
    bit                  m_err;
    logic [FLIT_WIDTH-1:0] m_flit;

    link_credit_tx #(
        .NUM_VCS    (NUM_VCS),
        .BUFFER_SIZE(BUFFER_SIZE),
        .FLIT_WIDTH (FLIT_WIDTH)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .flit_in     (flit_in),
        .flit_vc     (flit_vc),
        .flit_valid  (flit_valid),
        .flit_ready  (flit_ready),
        .credit_valid(credit_valid),
        .credit_vc   (credit_vc),
        .phy_start   (phy_start),
        .phy_flit    (phy_flit),
        .phy_done    (phy_done),
        .credits     (credits),
        .credit_err  (credit_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return !m_busy && (int'(flit_vc) < NUM_VCS) && (m_cred[flit_vc] > 0);
    endfunction

    function automatic logic [NUM_VCS*CNT_W-1:0] m_packed();
        logic [NUM_VCS*CNT_W-1:0] p;
        for (int v = 0; v < NUM_VCS; v++) p[v*CNT_W +: CNT_W] = CNT_W'(m_cred[v]);
        return p;
    endfunction

    task automatic apply(input logic [31:0] f, input logic [VC_W-1:0] vc, input logic v,
                         input logic cv, input logic [VC_W-1:0] cvc, input logic pd);
        flit_in = f; flit_vc = vc; flit_valid = v;
        credit_valid = cv; credit_vc = cvc; phy_done = pd;
        #1;
    endtask

    // Advance one edge and move the model by the same edge.
    task automatic tick();
        bit acc;
        @(posedge clk);
        if (!n_rst) begin
            m_busy = 0; m_age = 0; m_err = 0; m_flit = '0;
            for (int v = 0; v < NUM_VCS; v++) m_cred[v] = BUFFER_SIZE;
        end else begin
            acc = flit_valid && m_ready();
            if (m_busy) begin
                if (m_age >= 2 && phy_done) m_busy = 0;
                else m_age++;
            end
            if (acc) begin
                m_busy = 1; m_age = 1; m_flit = flit_in;
                m_cred[flit_vc] = m_cred[flit_vc] - 1;
            end
            if (credit_valid) begin
                if (int'(credit_vc) >= NUM_VCS) m_err = 1;
                else if (m_cred[credit_vc] + 1 > BUFFER_SIZE) m_err = 1;
                else m_cred[credit_vc] = m_cred[credit_vc] + 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        apply(0, 0, 0, 0, 0, 0);
        tick(); tick();
        n_rst = 1'b1;
        #1;
    endtask

    task automatic send_flit(input logic [31:0] d, input logic [VC_W-1:0] vc, input int delay);
        apply(d, vc, 1, 0, 0, 0); tick();
        apply(0, 0, 0, 0, 0, 0); tick();
        repeat (delay) tick();
        apply(0, 0, 0, 0, 0, 1); tick();
        apply(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (phy_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%0b exp=0", phy_start); end
        checks++; if (phy_flit !== 32'h0) begin errors++; $display("FAIL reset_flit got=%h exp=0", phy_flit); end
        checks++; if (credits !== 8'h88) begin errors++; $display("FAIL reset_credits got=%h exp=88", credits); end
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", credit_err); end
    endtask

    task automatic test_single();
        do_reset();
        apply(32'hDEADBEEF, 0, 1, 0, 0, 0);
        checks++; if (flit_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%0b exp=1", flit_ready); end
        tick();
        apply(0, 0, 0, 0, 0, 0);
        checks++; if (phy_start !== 1'b1) begin errors++; $display("FAIL single_start got=%0b exp=1", phy_start); end
        checks++; if (phy_flit !== 32'hDEADBEEF) begin errors++; $display("FAIL single_flit got=%h exp=deadbeef", phy_flit); end
        tick();
        checks++; if (phy_start !== 1'b0) begin errors++; $display("FAIL single_start_once got=%0b exp=0", phy_start); end
        checks++; if (credits !== 8'h87) begin errors++; $display("FAIL single_credits got=%h exp=87", credits); end
        tick();
        apply(0, 0, 0, 0, 0, 1);
        checks++; if (busy !== 1'b1 || phy_flit !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_hold busy=%0b flit=%h exp busy=1 flit=deadbeef", busy, phy_flit); end
        tick();
        apply(0, 0, 0, 0, 0, 0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop got=%0b exp=0", busy); end
    endtask

    task automatic test_exhaust();
        do_reset();
        for (int i = 0; i < 8; i++) send_flit($urandom, 1, 0);
        checks++; if (credits !== 8'h08) begin errors++; $display("FAIL exhaust_credits got=%h exp=08", credits); end
        apply(32'h1234, 1, 1, 0, 0, 0);
        checks++; if (flit_ready !== 1'b0) begin errors++; $display("FAIL exhaust_blocked got=%0b exp=0", flit_ready); end
        apply(32'h5678, 0, 1, 0, 0, 0);
        checks++; if (flit_ready !== 1'b1) begin errors++; $display("FAIL exhaust_vc0_ok got=%0b exp=1", flit_ready); end
        send_flit(32'h5678, 0, 0);
        apply(0, 1, 0, 1, 1, 0);
        checks++; if (flit_ready !== 1'b0) begin errors++; $display("FAIL exhaust_pre_credit got=%0b exp=0", flit_ready); end
        tick();
        apply(0, 1, 0, 0, 0, 0);
        checks++; if (flit_ready !== 1'b1) begin errors++; $display("FAIL exhaust_post_credit got=%0b exp=1", flit_ready); end
        checks++; if (credits !== 8'h17) begin errors++; $display("FAIL exhaust_final got=%h exp=17", credits); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 3; i++) send_flit($urandom, 0, 0);
        apply(32'hA, 0, 1, 1, 0, 0); tick();
        apply(0, 0, 0, 0, 0, 0);
        checks++; if (credits !== 8'h85) begin errors++; $display("FAIL simul_same got=%h exp=85", credits); end
        tick(); apply(0, 0, 0, 0, 0, 1); tick(); apply(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) send_flit($urandom, 1, 0);
        apply(32'hB, 0, 1, 1, 1, 0); tick();
        apply(0, 0, 0, 0, 0, 0);
        checks++; if (credits !== 8'h74) begin errors++; $display("FAIL simul_diff got=%h exp=74", credits); end
        tick(); apply(0, 0, 0, 0, 0, 1); tick(); apply(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_overflow();
        do_reset();
        apply(0, 0, 0, 1, 0, 0); tick();
        apply(0, 0, 0, 0, 0, 0);
        checks++; if (credits !== 8'h88 || credit_err !== 1'b1) begin
            errors++; $display("FAIL overflow credits=%h err=%0b exp credits=88 err=1", credits, credit_err); end
        send_flit($urandom, 0, 1);
        send_flit($urandom, 0, 0);
        checks++; if (credit_err !== 1'b1 || credits !== 8'h86) begin
            errors++; $display("FAIL overflow_sticky err=%0b credits=%h exp err=1 credits=86", credit_err, credits); end
        do_reset();
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL overflow_clear got=%0b exp=0", credit_err); end
    endtask

    task automatic test_reset_wait();
        do_reset();
        apply(32'hCAFE, 1, 1, 0, 0, 0); tick();
        apply(0, 0, 0, 0, 0, 0); tick(); tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstwait_busy got=%0b exp=1", busy); end
        n_rst = 1'b0; tick();
        checks++; if (busy !== 1'b0 || credits !== 8'h88 || phy_start !== 1'b0 || phy_flit !== 32'h0) begin
            errors++; $display("FAIL rstwait_state busy=%0b credits=%h start=%0b flit=%h exp 0/88/0/0",
                               busy, credits, phy_start, phy_flit); end
        n_rst = 1'b1;
        apply(0, 0, 0, 0, 0, 1); tick();
        apply(0, 0, 1, 0, 0, 0);
        checks++; if (credit_err !== 1'b0 || busy !== 1'b0 || flit_ready !== 1'b1) begin
            errors++; $display("FAIL rstwait_late_done err=%0b busy=%0b ready=%0b exp 0/0/1",
                               credit_err, busy, flit_ready); end
    endtask

    task automatic test_done_delay();
        do_reset();
        apply(0, 0, 0, 0, 0, 1); tick();
        apply(0, 0, 0, 0, 0, 0);
        checks++; if (busy !== 1'b0 || credit_err !== 1'b0 || credits !== 8'h88) begin
            errors++; $display("FAIL idle_done busy=%0b err=%0b credits=%h exp 0/0/88", busy, credit_err, credits); end
        apply(32'h77, 0, 1, 0, 0, 0); tick();
        apply(0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            apply(32'h99, 0, 1, 0, 0, 0);
            checks++; if (flit_ready !== 1'b0 || phy_flit !== 32'h77) begin
                errors++; $display("FAIL wait_hold cyc=%0d ready=%0b flit=%h exp 0/77", i, flit_ready, phy_flit); end
            tick();
        end
        apply(32'h99, 0, 1, 0, 0, 1);
        checks++; if (flit_ready !== 1'b0) begin errors++; $display("FAIL wait_done_cycle got=%0b exp=0", flit_ready); end
        tick();
        apply(32'h99, 0, 1, 0, 0, 0);
        checks++; if (flit_ready !== 1'b1) begin errors++; $display("FAIL wait_after_done got=%0b exp=1", flit_ready); end
    endtask

    task automatic test_random();
        logic pd;
        for (int c = 0; c < 600; c++) begin
            n_rst = ($urandom_range(0, 99) != 0);
            pd = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            apply($urandom, VC_W'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 3) == 0), VC_W'($urandom_range(0, 1)), pd);
            checks++; if (flit_ready !== m_ready()) begin
                errors++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", c, flit_ready, m_ready()); end
            checks++; if (phy_start !== (m_busy && m_age == 1) || busy !== m_busy) begin
                errors++; $display("FAIL rand_phase cyc=%0d start=%0b busy=%0b exp start=%0b busy=%0b",
                                   c, phy_start, busy, (m_busy && m_age == 1), m_busy); end
            checks++; if (credits !== m_packed() || credit_err !== m_err || phy_flit !== m_flit) begin
                errors++; $display("FAIL rand_state cyc=%0d credits=%h err=%0b flit=%h exp %h/%0b/%h",
                                   c, credits, credit_err, phy_flit, m_packed(), m_err, m_flit); end
            tick();
        end
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        apply(0, 0, 0, 0, 0, 0);
        test_reset();
        test_single();
        test_exhaust();
        test_simultaneous();
        test_overflow();
        test_reset_wait();
        test_done_delay();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/link_credit_tx.md
Name: link_credit_tx

Overview:
- Transmit-side credit tracker and flit sender for one inter-tile link.
- Sits between a switch output port and the physical-layer transmitter.
- Accepts flits from the switch and forwards them to the physical layer only when the downstream receiver's input buffer for that flit's VC has a free slot.
- Consumes the credit-return pulses that the downstream receiver emits as its buffer drains. It is the sending counterpart of the receiver's buffer_available/credit_granted path.

Parameters:
- NUM_VCS, 2, number of virtual channels tracked.
- BUFFER_SIZE, 8, downstream buffer depth per VC; this is the initial credit count.
- FLIT_WIDTH, 32, flit width in bits.
- Derived (localparam): VC_W = max(1, $clog2(NUM_VCS)); CNT_W = $clog2(BUFFER_SIZE+1).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset, synchronous, active-low.
- flit_in  in  FLIT_WIDTH  flit from switch output.
- flit_vc  in  VC_W  VC of flit_in.
- flit_valid  in  1  flit_in/flit_vc valid.
- flit_ready  out  1  block accepts the flit this cycle.
- credit_valid  in  1  one-cycle credit-return pulse from the downstream receiver.
- credit_vc  in  VC_W  VC being credited.
- phy_start  out  1  one-cycle start strobe to the physical transmitter.
- phy_flit  out  FLIT_WIDTH  flit to transmit; held stable from phy_start until phy_done.
- phy_done  in  1  physical transmitter finished the current flit.
- credits  out  NUM_VCS*CNT_W  current credit count per VC; VC0 in the LSBs.
- credit_err  out  1  sticky protocol-error flag.
- busy  out  1  a flit is in flight (state != IDLE).

Behaviour:
- Reset is synchronous and active-low. On the first posedge clk with n_rst=0:
  - state=IDLE;
  - every credits[v]=BUFFER_SIZE;
  - phy_flit=0, phy_start=0, credit_err=0, busy=0.
  - Reset mid-transfer abandons the flit. No phy_done is awaited and no credit is restored beyond BUFFER_SIZE.
- State machine is IDLE -> SEND -> WAIT -> IDLE.
- IDLE:
  - flit_ready = (flit_vc < NUM_VCS) && (credits[flit_vc] != 0). This is combinational from the current state and inputs.
  - On accept (flit_valid && flit_ready): phy_flit<=flit_in; credits[flit_vc] decrements; next state is SEND.
- SEND:
  - phy_start=1 for exactly this one cycle; flit_ready=0.
  - Next state is WAIT unconditionally.
- WAIT:
  - flit_ready=0; phy_flit is held.
  - On phy_done=1, go to IDLE. The next accept is possible in the cycle after phy_done.
- phy_done in IDLE or SEND is ignored and does not set credit_err.
- Latency: the flit accepted at edge N gives phy_start high in cycle N+1. Minimum flit period is 3 cycles when phy_done returns in the first WAIT cycle.
- Credit return:
  - When credit_valid=1 and credit_vc < NUM_VCS, credits[credit_vc] increments.
  - Simultaneous decrement and increment on the same VC leaves that count unchanged. On different VCs, both updates apply.
  - Overflow: an increment that would exceed BUFFER_SIZE (after any same-cycle decrement) saturates at BUFFER_SIZE and sets credit_err.
  - credit_valid with credit_vc >= NUM_VCS changes no counter and sets credit_err.
- credit_err stays at 1 until reset.
- Zero credit: flit_ready=0 for that VC. The flit waits on the switch side. A credit arriving in cycle N makes flit_ready=1 in cycle N+1.
- VCs with credit are never blocked by a zero-credit VC. Only the VC currently presented on flit_vc is evaluated.
- flit_vc >= NUM_VCS: flit_ready=0 forever for that flit. This is not an error; the switch must not issue it.
- Counter arithmetic is unsigned CNT_W bits and never wraps.

Test Plan:
- Reset, then one VC0 flit 0xDEADBEEF accepted at edge 1:
  - phy_start high in cycle 2 only;
  - phy_flit=0xDEADBEEF held until phy_done;
  - credits VC0=7, VC1=8;
  - busy drops the cycle after phy_done.
- Send 8 VC1 flits, each completed with phy_done, and no credits returned:
  - VC1 credits reach 0 and flit_ready=0 for the 9th VC1 flit;
  - a VC0 flit is still accepted;
  - one credit_valid with VC1 gives flit_ready=1 for VC1 the next cycle.
- Same-cycle accept on VC0 and credit_valid VC0 with VC0 at 5 -> VC0 stays 5. Same case with credit on VC1 (VC1 at 6) -> VC0=4, VC1=7.
- credit_valid VC0 at full credit (8):
  - count stays 8 and credit_err=1;
  - credit_err remains 1 across later traffic until n_rst=0.
- Reset asserted during WAIT:
  - next cycle state is IDLE, busy=0, all credits 8, phy_start=0;
  - a late phy_done after reset is ignored, with no credit_err.
- phy_done pulsed in IDLE, and a 5-cycle phy_done delay in WAIT:
  - the IDLE pulse has no effect;
  - flit_ready stays 0 through WAIT and becomes 1 the cycle after phy_done.
